// File: rtl/fft_pkg.sv
// Shared constants, encodings and index helpers for the 16-point FFT datapath.
// Holds the Q2.14 twiddle ROM and the butterfly pairing/twiddle-index functions.
package fft_pkg;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int CW = 2 * W;
  localparam int VW = N * CW;

  typedef logic [CW-1:0] cplx_t;

  localparam logic [2:0] SRC_DIN  = 3'b000;
  localparam logic [2:0] SRC_X    = 3'b001;
  localparam logic [2:0] SRC_A    = 3'b010;
  localparam logic [2:0] SRC_B    = 3'b011;
  localparam logic [2:0] SRC_C    = 3'b100;
  localparam logic [2:0] SRC_D    = 3'b101;
  localparam logic [2:0] SRC_XF   = 3'b110;
  localparam logic [2:0] SRC_ZERO = 3'b111;

  localparam logic [2:0] ROM_FIRST = 3'b001;
  localparam logic [2:0] ROM_LAST  = 3'b100;

  localparam logic [2:0] MAP_BITREV = 3'b001;

  localparam logic signed [W-1:0] TW_RE [8] = '{
    16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
    16'sd0, -16'sd6270, -16'sd11585, -16'sd15137
  };

  localparam logic signed [W-1:0] TW_IM [8] = '{
    16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
    -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
  };

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Lower index of butterfly i in a stage with half-span 2^sh.
  // The upper index is this value with bit sh set.
  function automatic logic [3:0] bf_lo(
    input logic [1:0] sh,
    input logic [2:0] i
  );
    logic [3:0] ii;
    logic [3:0] m;
    logic [3:0] j;
    logic [3:0] g;
    ii = {1'b0, i};
    m  = (4'd1 << sh) - 4'd1;
    j  = ii & m;
    g  = (ii >> sh) << (3'(sh) + 3'd1);
    return g | j;
  endfunction

  // Twiddle index j*8/h, with j the offset inside the group.
  function automatic logic [2:0] bf_tw(
    input logic [1:0] sh,
    input logic [2:0] i
  );
    logic [2:0] m;
    logic [2:0] j;
    m = 3'((4'd1 << sh) - 4'd1);
    j = i & m;
    return 3'(j << (2'd3 - sh));
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// One radix-2 complex butterfly: y0 = a + w*b, y1 = a - w*b, low 16 bits kept.
// Ports: a_i, b_i packed {re,im}; w_re_i/w_im_i Q2.14; y0_o, y1_o; ovf_o range flag.
module fft_butterfly
  import fft_pkg::*;
(
  input  cplx_t                a_i,
  input  cplx_t                b_i,
  input  logic signed [W-1:0]  w_re_i,
  input  logic signed [W-1:0]  w_im_i,
  output cplx_t                y0_o,
  output cplx_t                y1_o,
  output logic                 ovf_o
);

  logic signed [W-1:0] ar;
  logic signed [W-1:0] ai;
  logic signed [W-1:0] br;
  logic signed [W-1:0] bi;
  logic signed [31:0]  p_re;
  logic signed [31:0]  p_im;
  logic signed [31:0]  t_re;
  logic signed [31:0]  t_im;
  logic signed [31:0]  s0r;
  logic signed [31:0]  s0i;
  logic signed [31:0]  s1r;
  logic signed [31:0]  s1i;

  function automatic logic oor(input logic signed [31:0] v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Sums are held wide so the range check sees the true result;
  // only the low 16 bits are stored.
  always_comb begin
    ar    = a_i[CW-1:W];
    ai    = a_i[W-1:0];
    br    = b_i[CW-1:W];
    bi    = b_i[W-1:0];
    p_re  = br * w_re_i - bi * w_im_i;
    p_im  = br * w_im_i + bi * w_re_i;
    t_re  = p_re >>> 14;
    t_im  = p_im >>> 14;
    s0r   = ar + t_re;
    s0i   = ai + t_im;
    s1r   = ar - t_re;
    s1i   = ai - t_im;
    y0_o  = {s0r[W-1:0], s0i[W-1:0]};
    y1_o  = {s1r[W-1:0], s1i[W-1:0]};
    ovf_o = oor(s0r) | oor(s0i) | oor(s1r) | oor(s1i);
  end

endmodule

// File: rtl/data_path_top.sv
// 16-point radix-2 DIT FFT datapath: six vector registers and one butterfly stage.
// Ports: clock/reset/Local_reset, Wr_En_*/Rd_En_*, MAC_IN_Sel, ROMW_add, Sel_Mapping, Data_In, Data_Out, Overflow.
module data_path_top
  import fft_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          Local_reset,
  input  logic          Wr_En_x,
  input  logic          Wr_En_A,
  input  logic          Wr_En_B,
  input  logic          Wr_En_C,
  input  logic          Wr_En_D,
  input  logic          Wr_En_X,
  input  logic          Rd_En_x,
  input  logic          Rd_En_A,
  input  logic          Rd_En_B,
  input  logic          Rd_En_C,
  input  logic          Rd_En_D,
  input  logic          Rd_En_X,
  input  logic [2:0]    MAC_IN_Sel,
  input  logic [2:0]    ROMW_add,
  input  logic [2:0]    Sel_Mapping,
  input  logic [VW-1:0] Data_In,
  output logic [VW-1:0] Data_Out,
  output logic          Overflow
);

  logic [VW-1:0] x_q, x_d;
  logic [VW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;
  logic [VW-1:0] c_q, c_d;
  logic [VW-1:0] d_q, d_d;
  logic [VW-1:0] xf_q, xf_d;
  logic          ovf_q, ovf_d;

  logic [VW-1:0] s_vec;
  logic [VW-1:0] p_vec;
  logic [VW-1:0] y_vec;
  logic          stage_en;
  logic [1:0]    sh;
  logic          any_wr;

  logic [3:0]    lo_idx [8];
  logic [3:0]    hi_idx [8];
  logic [2:0]    tw_idx [8];
  cplx_t         bf_a   [8];
  cplx_t         bf_b   [8];
  cplx_t         bf_y0  [8];
  cplx_t         bf_y1  [8];
  logic [7:0]    bf_ovf;

  always_comb begin
    case (MAC_IN_Sel)
      SRC_DIN:  s_vec = Data_In;
      SRC_X:    s_vec = Rd_En_x ? x_q  : '0;
      SRC_A:    s_vec = Rd_En_A ? a_q  : '0;
      SRC_B:    s_vec = Rd_En_B ? b_q  : '0;
      SRC_C:    s_vec = Rd_En_C ? c_q  : '0;
      SRC_D:    s_vec = Rd_En_D ? d_q  : '0;
      SRC_XF:   s_vec = Rd_En_X ? xf_q : '0;
      SRC_ZERO: s_vec = '0;
      default:  s_vec = '0;
    endcase
  end

  always_comb begin
    p_vec = s_vec;
    if (Sel_Mapping == MAP_BITREV) begin
      for (int k = 0; k < N; k++) begin
        p_vec[CW*k +: CW] = s_vec[CW*bitrev4(4'(k)) +: CW];
      end
    end
  end

  always_comb begin
    stage_en = (ROMW_add >= ROM_FIRST) && (ROMW_add <= ROM_LAST);
    sh       = 2'(ROMW_add - 3'd1);
    for (int i = 0; i < 8; i++) begin
      lo_idx[i] = bf_lo(sh, 3'(i));
      hi_idx[i] = lo_idx[i] | (4'd1 << sh);
      tw_idx[i] = bf_tw(sh, 3'(i));
      bf_a[i]   = p_vec[CW*lo_idx[i] +: CW];
      bf_b[i]   = p_vec[CW*hi_idx[i] +: CW];
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bf
    fft_butterfly u_bf (
      .a_i    (bf_a[gi]),
      .b_i    (bf_b[gi]),
      .w_re_i (TW_RE[tw_idx[gi]]),
      .w_im_i (TW_IM[tw_idx[gi]]),
      .y0_o   (bf_y0[gi]),
      .y1_o   (bf_y1[gi]),
      .ovf_o  (bf_ovf[gi])
    );
  end

  always_comb begin
    y_vec = p_vec;
    if (stage_en) begin
      for (int i = 0; i < 8; i++) begin
        y_vec[CW*lo_idx[i] +: CW] = bf_y0[i];
        y_vec[CW*hi_idx[i] +: CW] = bf_y1[i];
      end
    end
  end

  always_comb begin
    any_wr = Wr_En_A | Wr_En_B | Wr_En_C | Wr_En_D | Wr_En_X;
    x_d    = Wr_En_x ? Data_In : x_q;
    a_d    = Wr_En_A ? y_vec : a_q;
    b_d    = Wr_En_B ? y_vec : b_q;
    c_d    = Wr_En_C ? y_vec : c_q;
    d_d    = Wr_En_D ? y_vec : d_q;
    xf_d   = Wr_En_X ? y_vec : xf_q;
    ovf_d  = ovf_q | (stage_en & any_wr & (|bf_ovf));
    if (Local_reset) begin
      x_d   = '0;
      a_d   = '0;
      b_d   = '0;
      c_d   = '0;
      d_d   = '0;
      xf_d  = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      xf_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      xf_q  <= xf_d;
      ovf_q <= ovf_d;
    end
  end

  assign Data_Out = xf_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_data_path_top.sv
// Directed and random checks of data_path_top against an array-based FFT stage model.
// Drives one control word per cycle; samples Data_Out/Overflow 1 time unit after each edge.
module tb_data_path_top;

  logic         clock = 1'b0;
  logic         reset;
  logic         Local_reset;
  logic         Wr_En_x, Wr_En_A, Wr_En_B, Wr_En_C, Wr_En_D, Wr_En_X;
  logic         Rd_En_x, Rd_En_A, Rd_En_B, Rd_En_C, Rd_En_D, Rd_En_X;
  logic [2:0]   MAC_IN_Sel;
  logic [2:0]   ROMW_add;
  logic [2:0]   Sel_Mapping;
  logic [511:0] Data_In;
  logic [511:0] Data_Out;
  logic         Overflow;

  int checks = 0;
  int errors = 0;

  int TWR [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int TWI [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

  logic [511:0] mreg [6];
  logic         movf;

  data_path_top dut (
    .clock       (clock),
    .reset       (reset),
    .Local_reset (Local_reset),
    .Wr_En_x     (Wr_En_x),
    .Wr_En_A     (Wr_En_A),
    .Wr_En_B     (Wr_En_B),
    .Wr_En_C     (Wr_En_C),
    .Wr_En_D     (Wr_En_D),
    .Wr_En_X     (Wr_En_X),
    .Rd_En_x     (Rd_En_x),
    .Rd_En_A     (Rd_En_A),
    .Rd_En_B     (Rd_En_B),
    .Rd_En_C     (Rd_En_C),
    .Rd_En_D     (Rd_En_D),
    .Rd_En_X     (Rd_En_X),
    .MAC_IN_Sel  (MAC_IN_Sel),
    .ROMW_add    (ROMW_add),
    .Sel_Mapping (Sel_Mapping),
    .Data_In     (Data_In),
    .Data_Out    (Data_Out),
    .Overflow    (Overflow)
  );

  always #5 clock = ~clock;

  function automatic int rev4(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++) r |= ((k >> b) & 1) << (3 - b);
    return r;
  endfunction

  function automatic logic [511:0] splat(input int re, input int im);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = {16'(re), 16'(im)};
    return v;
  endfunction

  function automatic logic [511:0] rand_vec(input bit full);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) begin
      if (full) v[32*k +: 32] = $urandom;
      else v[32*k +: 32] = {16'($urandom_range(0, 4000) - 2000),
                            16'($urandom_range(0, 4000) - 2000)};
    end
    return v;
  endfunction

  // Spec-level stage: permute, then butterflies with integer arithmetic.
  task automatic model_y(input logic [511:0] src, input logic [2:0] rom,
                         input logic [2:0] map, output logic [511:0] y,
                         output bit ovf);
    int pr [16];
    int pi [16];
    int yr [16];
    int yi [16];
    ovf = 0;
    for (int k = 0; k < 16; k++) begin
      int idx = (map == 3'b001) ? rev4(k) : k;
      pr[k] = int'($signed(src[32*idx+16 +: 16]));
      pi[k] = int'($signed(src[32*idx +: 16]));
      yr[k] = pr[k];
      yi[k] = pi[k];
    end
    if (rom >= 3'd1 && rom <= 3'd4) begin
      int h = 1 << (int'(rom) - 1);
      for (int g = 0; g < 16; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int t  = j * 8 / h;
          int br = pr[g+j+h];
          int bi = pi[g+j+h];
          int tr = (br * TWR[t] - bi * TWI[t]) >>> 14;
          int ti = (br * TWI[t] + bi * TWR[t]) >>> 14;
          yr[g+j]   = pr[g+j] + tr;
          yi[g+j]   = pi[g+j] + ti;
          yr[g+j+h] = pr[g+j] - tr;
          yi[g+j+h] = pi[g+j] - ti;
        end
      end
      for (int k = 0; k < 16; k++) begin
        if (yr[k] > 32767 || yr[k] < -32768) ovf = 1;
        if (yi[k] > 32767 || yi[k] < -32768) ovf = 1;
      end
    end
    for (int k = 0; k < 16; k++) y[32*k +: 32] = {16'(yr[k]), 16'(yi[k])};
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] sel, input logic [2:0] rom,
                      input logic [2:0] map, input logic [5:0] rd,
                      input logic [5:0] wr, input logic [511:0] din,
                      input logic lrst);
    logic [511:0] src;
    logic [511:0] y;
    bit o;
    {Rd_En_X, Rd_En_D, Rd_En_C, Rd_En_B, Rd_En_A, Rd_En_x} = rd;
    {Wr_En_X, Wr_En_D, Wr_En_C, Wr_En_B, Wr_En_A, Wr_En_x} = wr;
    MAC_IN_Sel  = sel;
    ROMW_add    = rom;
    Sel_Mapping = map;
    Data_In     = din;
    Local_reset = lrst;
    src = '0;
    if (sel == 3'd0) src = din;
    else if (sel != 3'd7 && rd[int'(sel)-1]) src = mreg[int'(sel)-1];
    model_y(src, rom, map, y, o);
    @(posedge clock);
    #1;
    if (lrst) begin
      for (int r = 0; r < 6; r++) mreg[r] = '0;
      movf = 0;
    end else begin
      if (wr[0]) mreg[0] = din;
      for (int r = 1; r < 6; r++) if (wr[r]) mreg[r] = y;
      if ((|wr[5:1]) && o) movf = 1;
    end
    chk("model_data_out", Data_Out, mreg[5]);
    chk("model_overflow", 512'(Overflow), 512'(movf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 6; r++) mreg[r] = '0;
    movf = 0;
    chk("reset_data_out", Data_Out, '0);
    chk("reset_overflow", 512'(Overflow), 512'(0));
  endtask

  task automatic canon(input logic [511:0] din);
    step(3'd0, 3'd0, 3'd0, 6'b0, 6'b000001, din, 1'b0);
    for (int s = 1; s <= 5; s++)
      step(3'(s), 3'(s), 3'(s), 6'(1 << (s - 1)), 6'(1 << s), '0, 1'b0);
  endtask

  initial begin
    logic [511:0] v;
    logic [511:0] e;
    reset = 1'b0;
    step(3'd7, 3'd0, 3'd0, '0, '0, '0, 1'b0);
    do_reset();

    v = '0;
    v[31:0] = {16'd100, 16'd0};
    canon(v);
    chk("impulse_bins", Data_Out, splat(100, 0));
    chk("impulse_ovf", 512'(Overflow), 512'(0));

    canon(splat(10, 0));
    e = '0;
    e[31:0] = {16'd160, 16'd0};
    chk("dc_bins", Data_Out, e);

    v = rand_vec(1);
    step(3'd0, 3'd0, 3'd0, '0, 6'b000001, v, 1'b0);
    step(3'd1, 3'd0, 3'd0, 6'b000001, 6'b100000, '0, 1'b0);
    chk("bypass_identity", Data_Out, v);
    step(3'd1, 3'd0, 3'd1, 6'b000001, 6'b100000, '0, 1'b0);
    for (int k = 0; k < 16; k++) e[32*k +: 32] = v[32*rev4(k) +: 32];
    chk("bypass_bitrev", Data_Out, e);

    step(3'd1, 3'd0, 3'd0, 6'b000001, 6'b000010, '0, 1'b0);
    step(3'd1, 3'd0, 3'd0, 6'b000000, 6'b000010, '0, 1'b0);
    step(3'd2, 3'd0, 3'd0, 6'b000010, 6'b100000, '0, 1'b0);
    chk("read_gate_A", Data_Out, '0);

    for (int n = 0; n < 60; n++) begin
      step(3'($urandom), 3'($urandom), 3'($urandom), 6'($urandom),
           6'($urandom), rand_vec(n[0]), ($urandom_range(0, 15) == 0));
    end
    canon(rand_vec(0));
    for (int s = 1; s <= 4; s++)
      step(3'd6, 3'($urandom), 3'($urandom), 6'b100000, 6'b100000,
           '0, 1'b0);

    step(3'd0, 3'd0, 3'd0, '0, 6'b100001, rand_vec(1), 1'b0);
    do_reset();

    canon(rand_vec(1));
    step(3'd0, 3'd0, 3'd0, '0, 6'b000001, splat(30000, 0), 1'b0);
    step(3'd1, 3'd1, 3'd1, 6'b000001, 6'b000010, '0, 1'b0);
    chk("ovf_after_stage1", 512'(Overflow), 512'(1));
    for (int s = 2; s <= 5; s++)
      step(3'(s), 3'(s), 3'(s), 6'(1 << (s - 1)), 6'(1 << s), '0, 1'b0);
    chk("ovf_sticky", 512'(Overflow), 512'(1));
    step(3'd7, 3'd0, 3'd0, '0, 6'b111111, rand_vec(1), 1'b1);
    chk("lrst_overflow", 512'(Overflow), 512'(0));
    chk("lrst_data_out", Data_Out, '0);
    step(3'd1, 3'd0, 3'd0, 6'b000001, 6'b100000, '0, 1'b0);
    chk("lrst_x_cleared", Data_Out, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_path_top.md
# data_path_top

16-point radix-2 decimation-in-time FFT datapath, one 16-bit-complex vector per cycle. Holds six 512-bit vector registers (input x, stage results A–D, spectrum X) and one combinational butterfly stage whose source, twiddle set and input permutation come from an external controller. The controller steps x→A→B→C→D→X, one stage per clock. Data_Out exposes the final spectrum register X.

## Interface
- N, 16: points per transform.
- W, 16: bits per real or imaginary component.
- clock  in  1  rising-edge clock; all registers use it.
- reset  in  1  synchronous, active-high; clears all registers and Overflow.
- Local_reset  in  1  synchronous, active-high soft clear; same effect as reset.
- Wr_En_x, Wr_En_A, Wr_En_B, Wr_En_C, Wr_En_D, Wr_En_X  in  1 each  load enable of the named register.
- Rd_En_x, Rd_En_A, Rd_En_B, Rd_En_C, Rd_En_D, Rd_En_X  in  1 each  read gate; a register drives the source mux only while its Rd_En is high, otherwise it contributes zero.
- MAC_IN_Sel  in  3  source select: 000 Data_In, 001 x, 010 A, 011 B, 100 C, 101 D, 110 X, 111 zero.
- ROMW_add  in  3  stage select: 001–100 = butterfly stage 1–4; any other value = bypass.
- Sel_Mapping  in  3  input permutation: 001 = 4-bit bit-reversal; any other value = identity.
- Data_In  in  512  sample k = Data_In[32k+31:32k]: real in [31:16], imaginary in [15:0], two's complement.
- Data_Out  out  512  contents of X, same packing.
- Overflow  out  1  sticky overflow flag.

## Operation
- x is loaded from Data_In directly when Wr_En_x is high.
- Stage path, combinational, in this order:
  - S = gated register chosen by MAC_IN_Sel.
  - P = S after the Sel_Mapping permutation.
  - Y = P after the ROMW_add stage, or Y = P when ROMW_add is bypass.
- A, B, C, D and X load Y when their Wr_En is high. Several enables high at once all load in the same cycle.
- Stage s, with h = 2^(s-1): for each group base g and j in 0..h-1, take a = P[g+j] and b = P[g+j+h].
  - Y[g+j] = a + W·b; Y[g+j+h] = a − W·b.
  - W = W16^(j·8/h).
- Twiddle ROM holds 8 entries, Q2.14, (re, im) for k = 0..7:
  - (16384,0) (15137,−6270) (11585,−11585) (6270,−15137)
  - (0,−16384) (−6270,−15137) (−11585,−11585) (−15137,−6270)
- Complex multiply:
  - re = (br·wr − bi·wi) >>> 14; im = (br·wi + bi·wr) >>> 14.
  - Products are 32-bit; shift is arithmetic truncation.
- Add/subtract in 17 bits. Each result is stored as its low 16 bits (wrap).
- Overflow: a result outside [−32768, 32767] in a cycle where any of Wr_En_A..X is high sets Overflow. It stays set until reset or Local_reset.
- Canonical sequence: sel/ROM/map = 001/001/001, then 010/010/010, 011/011/011, 100/100/100, 101/101/101. This yields X in natural bin order, unscaled.

## Timing
- All registers and Overflow update on the rising edge of clock. Control and Data_In are sampled at that edge.
- One stage per cycle. Stage result appears in its destination one cycle after the enable is sampled.
- Full transform: 6 cycles from Wr_En_x to valid Data_Out.
- Priority: reset > Local_reset > writes.
- Reset values: x, A, B, C, D, X = 0; Data_Out = 0; Overflow = 0.
- Read-before-write: a register that is both source and destination receives the value computed from its pre-edge contents.

## Structure
- Package fft_pkg:
  - N, W and the twiddle ROM constant array.
  - MAC_IN_Sel, ROMW_add and Sel_Mapping encodings.
  - bit-reverse function.
- Sub-module fft_butterfly: one complex butterfly (a, b, twiddle → two outputs plus overflow). Instantiated 8 times in the stage generate loop.

## Test plan
- Reset: drive reset, or later Local_reset, with random register contents → Data_Out = 0 and Overflow = 0 on the next cycle.
- Impulse: x[0] = 100+0j, others 0; canonical sequence → all 16 bins = 100+0j, Overflow = 0.
- DC: all samples 10+0j; canonical sequence → X[0] = 160+0j, bins 1–15 = 0.
- Bypass: MAC_IN_Sel = 001, Rd_En_x = 1, ROMW_add = 000, Sel_Mapping = 000, Wr_En_X = 1 → Data_Out equals x exactly. Repeat with Sel_Mapping = 001 → X[k] = x[bitrev(k)].
- Read gate: MAC_IN_Sel = 001, Rd_En_x = 0, Wr_En_A = 1 → A = 0.
- Overflow: all samples 30000+0j; canonical sequence → Overflow = 1 after the stage-1 write and stays 1. Local_reset then clears Overflow and all registers.
